// File: rtl/return_stack_pkg.sv
// Shared constants and helpers for the return-address stack.
// The fetch/PC-select logic reuses the defaults and the count-width helper.
package return_stack_pkg;

  localparam int RS_DEPTH_DEF = 8;
  localparam int RS_WIDTH_DEF = 16;

  // Width of a counter holding 0..depth inclusive
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int RS_CNT_W_DEF = cnt_width(RS_DEPTH_DEF);

  // Resolved operation for one clock edge
  typedef enum logic [2:0] {
    RS_OP_IDLE,
    RS_OP_PUSH,
    RS_OP_POP,
    RS_OP_REPLACE,
    RS_OP_DROP_PUSH,
    RS_OP_DROP_POP
  } rs_op_e;

  // Priority: push+pop on a non-empty stack replaces the top entry.
  // Push+pop on an empty stack degrades to a plain push.
  function automatic rs_op_e decode_op(input logic push, input logic pop,
                                       input logic full, input logic empty);
    if (push && pop && !empty) return RS_OP_REPLACE;
    if (push)                  return full  ? RS_OP_DROP_PUSH : RS_OP_PUSH;
    if (pop)                   return empty ? RS_OP_DROP_POP  : RS_OP_POP;
    return RS_OP_IDLE;
  endfunction

endpackage

// File: rtl/return_stack_if.sv
// Request/response bundle of the return-address stack.
// master: the CALL/RET sequencer; slave: return_stack.
interface return_stack_if #(
  parameter int DEPTH = return_stack_pkg::RS_DEPTH_DEF,
  parameter int WIDTH = return_stack_pkg::RS_WIDTH_DEF
);
  import return_stack_pkg::*;

  localparam int CNT_W = cnt_width(DEPTH);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] top_data;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             err;

  modport master (
    output push, pop, push_data,
    input  top_data, count, full, empty, err
  );

  modport slave (
    input  push, pop, push_data,
    output top_data, count, full, empty, err
  );

endinterface

// File: rtl/return_stack_stack_ptr.sv
// Stack pointer: up/down entry counter plus full/empty decode.
// Also resolves push/pop into one operation so storage and counter agree.
module stack_ptr
  import return_stack_pkg::*;
#(
  parameter  int DEPTH = RS_DEPTH_DEF,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output rs_op_e           op
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Decode status from the stored count and resolve the requested operation
  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    empty = (count_q == '0);
    op    = decode_op(push, pop, full, empty);
    count = count_q;
  end

  // Next count: only real pushes and pops move it; dropped requests hold it
  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    unique case (op)
      RS_OP_PUSH: count_d = count_q + CNT_W'(1);
      RS_OP_POP:  count_d = count_q - CNT_W'(1);
      default:    count_d = count_q;
    endcase
  end

  // Count register, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/return_stack.sv
// Return-address stack for CALL/RET.
// Optional sticky misuse flag: define RETURN_STACK_ERR_EN to build the err
// register; otherwise err is tied low.
module return_stack
  import return_stack_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH_DEF,
  parameter int WIDTH = RS_WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  return_stack_if.slave  bus
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int IDX_W = $clog2(DEPTH);

  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  rs_op_e           op;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;
  logic [WIDTH-1:0] top_data;

  stack_ptr #(.DEPTH(DEPTH)) u_stack_ptr (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.push),
    .pop   (bus.pop),
    .count (count),
    .full  (full),
    .empty (empty),
    .op    (op)
  );

  // Write address: next free slot on push, current top on replace
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    top_idx = IDX_W'(count - CNT_W'(1));
    if (!rst) begin
      unique case (op)
        RS_OP_PUSH: begin
          wr_en  = 1'b1;
          wr_idx = count[IDX_W-1:0];
        end
        RS_OP_REPLACE: begin
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end
        default: wr_en = 1'b0;
      endcase
    end
  end

  // Storage write; contents are unobservable while empty, so they are not reset
  always_ff @(posedge clk) begin
    // NOTE: memory arrays carry no reset so they map onto plain RAM/regfile cells.
    if (wr_en) mem_q[wr_idx] <= bus.push_data;
  end

  // Top-of-stack read, forced to zero when nothing is stored
  always_comb begin
    top_data = empty ? '0 : mem_q[top_idx];
  end

  assign bus.top_data = top_data;
  assign bus.count    = count;
  assign bus.full     = full;
  assign bus.empty    = empty;

`ifdef RETURN_STACK_ERR_EN
  logic err_q;
  logic err_d;

  // Sticky misuse flag: dropped push when full or dropped pop when empty
  always_comb begin
    err_d = err_q | (op == RS_OP_DROP_PUSH) | (op == RS_OP_DROP_POP);
  end

  // Error register, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_return_stack.sv
// Scoreboard bench for return_stack: the driver queues the expected visible
// state after each step and signals the monitor, which pops and compares.
module tb_return_stack;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

`ifdef RETURN_STACK_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct {
    string            name;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] top;
    logic             full;
    logic             empty;
    logic             err;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  exp_t sb_q [$];
  event obs_ev;

  return_stack_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  return_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got count=%0d full=%0b empty=%0b err=%0b top=0x%04h, expected count=%0d full=%0b empty=%0b err=%0b top=0x%04h",
               name, act[22:19], act[18], act[17], act[16], act[15:0],
               exp[22:19], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  // Monitor: compare queued expectations against the DUT when signalled
  initial begin
    exp_t e;
    forever begin
      @(obs_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name,
              {bus.count, bus.full, bus.empty, bus.err, bus.top_data},
              {e.cnt, e.full, e.empty, e.err, e.top});
      end
    end
  end

  task automatic expect_st(input string n, input int c, input logic [WIDTH-1:0] t,
                           input logic f, input logic e, input logic er);
    exp_t x;
    x.name  = n;
    x.cnt   = CNT_W'(c);
    x.top   = t;
    x.full  = f;
    x.empty = e;
    x.err   = er;
    sb_q.push_back(x);
    -> obs_ev;
  endtask

  task automatic do_op(input logic p, input logic q, input logic [WIDTH-1:0] d);
    @(negedge clk);
    bus.push      = p;
    bus.pop       = q;
    bus.push_data = d;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  // Assert reset between edges and check the state before any clock edge
  task automatic async_reset(input string n);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    expect_st(n, 0, 16'h0000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.push = 1'b1;
    bus.pop = 1'b0;
    bus.push_data = 16'h1234;

    // Reset held across edges with push requested: must stay empty
    repeat (2) @(posedge clk);
    #1;
    expect_st("reset_hold", 0, 16'h0000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.push = 1'b0;
    #1;
    expect_st("post_reset", 0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Three pushes then three pops
    do_op(1'b1, 1'b0, 16'h0010); expect_st("push1", 1, 16'h0010, 1'b0, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 16'h0020); expect_st("push2", 2, 16'h0020, 1'b0, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 16'h0030); expect_st("push3", 3, 16'h0030, 1'b0, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 16'h0000); expect_st("pop1",  2, 16'h0020, 1'b0, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 16'h0000); expect_st("pop2",  1, 16'h0010, 1'b0, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 16'h0000); expect_st("pop3",  0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Fill to DEPTH, then overflow, replace at full, and pop
    for (int i = 1; i <= DEPTH; i++) begin
      do_op(1'b1, 1'b0, WIDTH'(i));
      expect_st($sformatf("fill%0d", i), i, WIDTH'(i), (i == DEPTH), 1'b0, 1'b0);
    end
    do_op(1'b1, 1'b0, 16'h00FF); expect_st("overflow",     8, 16'h0008, 1'b1, 1'b0, EXP_ERR);
    do_op(1'b1, 1'b1, 16'h0EEE); expect_st("replace_full", 8, 16'h0EEE, 1'b1, 1'b0, EXP_ERR);
    do_op(1'b0, 1'b1, 16'h0000); expect_st("pop_from_full", 7, 16'h0007, 1'b0, 1'b0, EXP_ERR);
    async_reset("reset_from_7");

    // Simultaneous push and pop
    do_op(1'b1, 1'b0, 16'h0111); expect_st("pp_setup1", 1, 16'h0111, 1'b0, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 16'h0AAA); expect_st("pp_setup2", 2, 16'h0AAA, 1'b0, 1'b0, 1'b0);
    do_op(1'b1, 1'b1, 16'h0BBB); expect_st("push_pop",  2, 16'h0BBB, 1'b0, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 16'h0000); expect_st("pp_pop1",   1, 16'h0111, 1'b0, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 16'h0000); expect_st("pp_pop2",   0, 16'h0000, 1'b0, 1'b1, 1'b0);
    do_op(1'b1, 1'b1, 16'h0CCC); expect_st("push_pop_empty", 1, 16'h0CCC, 1'b0, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 16'h0000); expect_st("ppe_pop",   0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Underflow and stickiness of err
    do_op(1'b0, 1'b1, 16'h0000); expect_st("underflow",  0, 16'h0000, 1'b0, 1'b1, EXP_ERR);
    do_op(1'b0, 1'b0, 16'h0000); expect_st("err_sticky", 0, 16'h0000, 1'b0, 1'b1, EXP_ERR);
    async_reset("reset_clear_err");

    // Reset between edges with five entries stored
    for (int i = 1; i <= 5; i++) do_op(1'b1, 1'b0, WIDTH'(i * 16'h0101));
    expect_st("count5", 5, 16'h0505, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    expect_st("reset_cnt5", 0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Push held across an edge during reset is ignored; first edge after release acts
    @(negedge clk);
    bus.push      = 1'b1;
    bus.push_data = 16'h0777;
    @(posedge clk);
    #1;
    expect_st("push_in_reset", 0, 16'h0000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    expect_st("first_after_reset", 1, 16'h0777, 1'b0, 1'b0, 1'b0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) #1;
    if (sb_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 Parameter DEPTH, default 8, number of stack entries; legal values are powers of two, 2 to 64.
REQ-002 Parameter WIDTH, default 16, width of each stored word (return address).
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port push, input, 1 bit: write push_data onto the stack (CALL).
REQ-006 Port pop, input, 1 bit: remove the top entry (RET).
REQ-007 Port push_data, input, WIDTH bits: word to store.
REQ-008 Port top_data, output, WIDTH bits: current top entry, combinational from storage.
REQ-009 Port count, output, log2(DEPTH)+1 bits: number of valid entries.
REQ-010 Port full, output, 1 bit: high when count == DEPTH.
REQ-011 Port empty, output, 1 bit: high when count == 0.
REQ-012 Port err, output, 1 bit: sticky misuse flag (see Configuration).

Function
REQ-013 Push alone, not full: store push_data at index count, then count+1 on the same edge.
REQ-014 Pop alone, not empty: count-1; the popped word is the value top_data held before the edge.
REQ-015 Push and pop together, not empty: overwrite the top entry with push_data; count unchanged.
REQ-016 Push and pop together, empty: treat as push alone; count becomes 1.
REQ-017 Push alone when full: storage and count unchanged; request dropped.
REQ-018 Pop alone when empty: count stays 0; request dropped.
REQ-019 top_data = entry[count-1] when not empty; all-zero when empty.
REQ-020 Latency: a pushed word appears on top_data in the cycle after the push edge; pop updates top_data in the cycle after the pop edge.
REQ-021 full and empty are decoded combinationally from count; they are never both high.
REQ-022 count never exceeds DEPTH and never wraps below 0.

Reset
REQ-023 Asserting rst immediately sets count=0, empty=1, full=0, top_data=0, err=0, with no clock edge required.
REQ-024 Storage contents need not be cleared; they are unobservable while empty.
REQ-025 push and pop are ignored while rst is high; the first operation takes effect on the first rising edge after deassertion.

Configuration
REQ-026 Macro RETURN_STACK_ERR_EN defined: err sets on push-alone-when-full or pop-alone-when-empty and holds until rst.
REQ-027 Macro RETURN_STACK_ERR_EN undefined: err is tied to 0, and no error register is synthesized.

Structure
REQ-028 The shared package holds the DEPTH/WIDTH defaults and the count-width constant, because the fetch/PC-select logic also uses them.
REQ-029 One sub-module, stack_ptr, contains the up/down counter and the full/empty decode; return_stack contains the storage and top-of-stack read.

Verification
REQ-030 Reset, then push 0x0010, 0x0020, 0x0030 on consecutive cycles -> count=3, top_data=0x0030, empty=0.
REQ-031 From REQ-030, pop three times -> top_data reads 0x0020, then 0x0010, then 0; count=0, empty=1.
REQ-032 Push 8 words 0x0001..0x0008, then push 0x00FF -> full=1, count=8, top_data=0x0008; err=1 only with RETURN_STACK_ERR_EN defined.
REQ-033 Stack with count=2 and top 0x0AAA, apply push=pop=1 with 0x0BBB -> count=2, top_data=0x0BBB.
REQ-034 Pop while empty -> count=0 and top_data=0; err=1 only with RETURN_STACK_ERR_EN defined.
REQ-035 Assert rst between clock edges with count=5 -> count=0, empty=1, err=0 before the next edge.
